// File: rtl/cpu_pkg.sv
// Shared encodings for the control unit, register unit and datapath.
package cpu_pkg;

  localparam int unsigned OpNop   = 'h00;
  localparam int unsigned OpLdac  = 'h01;
  localparam int unsigned OpStac  = 'h02;
  localparam int unsigned OpMvacr = 'h03;
  localparam int unsigned OpMvrac = 'h04;
  localparam int unsigned OpAdd   = 'h05;
  localparam int unsigned OpSub   = 'h06;
  localparam int unsigned OpIncac = 'h07;
  localparam int unsigned OpClac  = 'h08;
  localparam int unsigned OpJump  = 'h09;
  localparam int unsigned OpJmpz  = 'h0A;
  localparam int unsigned OpEnd   = 'h3F;

  // C-bus write-enable bit positions
  localparam int unsigned CPc = 0;
  localparam int unsigned CAr = 1;
  localparam int unsigned CAc = 2;
  localparam int unsigned CR  = 3;
  localparam int unsigned CR1 = 4;
  localparam int unsigned CR2 = 5;
  localparam int unsigned CR3 = 6;
  localparam int unsigned CR4 = 7;
  localparam int unsigned CDr = 8;
  localparam int unsigned CTr = 9;

  // B-bus source codes
  localparam int unsigned BselNone = 0;
  localparam int unsigned BselPc   = 1;
  localparam int unsigned BselAr   = 2;
  localparam int unsigned BselAc   = 3;
  localparam int unsigned BselR    = 4;
  localparam int unsigned BselDr   = 5;
  localparam int unsigned BselIram = 6;

  // ALU operation codes
  localparam int unsigned AluPass = 0;
  localparam int unsigned AluAdd  = 1;
  localparam int unsigned AluSub  = 2;
  localparam int unsigned AluInc  = 3;
  localparam int unsigned AluClr  = 4;

  typedef enum logic [3:0] {
    StIdle, StF1, StF2, StDec, StEx, StMrd, StMwb, StMwr, StJ1, StJ2, StJskip, StHalt
  } state_e;

  // ClsAluR: AC <= ALU(R); ClsAluAc: AC <= ALU(AC) with no B-bus source
  typedef enum logic [3:0] {
    ClsNop, ClsLdac, ClsStac, ClsMvacr, ClsAluR, ClsAluAc, ClsJump, ClsJmpz, ClsEnd, ClsIllegal
  } instr_cls_e;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decode into instruction class, ALU op and legality.
module ctrl_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output instr_cls_e          cls_o,
  output logic [ALUOP_W-1:0]  alu_op_o,
  output logic                legal_o
);

  // Full-width compare so no upper-bit patterns alias onto legal opcodes
  always_comb begin
    cls_o    = ClsIllegal;
    alu_op_o = ALUOP_W'(AluPass);
    legal_o  = 1'b1;
    case (opcode_i)
      OPCODE_W'(OpNop):   cls_o = ClsNop;
      OPCODE_W'(OpLdac):  cls_o = ClsLdac;
      OPCODE_W'(OpStac):  cls_o = ClsStac;
      OPCODE_W'(OpMvacr): cls_o = ClsMvacr;
      OPCODE_W'(OpMvrac): cls_o = ClsAluR;
      OPCODE_W'(OpAdd): begin
        cls_o    = ClsAluR;
        alu_op_o = ALUOP_W'(AluAdd);
      end
      OPCODE_W'(OpSub): begin
        cls_o    = ClsAluR;
        alu_op_o = ALUOP_W'(AluSub);
      end
      OPCODE_W'(OpIncac): begin
        cls_o    = ClsAluAc;
        alu_op_o = ALUOP_W'(AluInc);
      end
      OPCODE_W'(OpClac): begin
        cls_o    = ClsAluAc;
        alu_op_o = ALUOP_W'(AluClr);
      end
      OPCODE_W'(OpJump):  cls_o = ClsJump;
      OPCODE_W'(OpJmpz):  cls_o = ClsJmpz;
      OPCODE_W'(OpEnd):   cls_o = ClsEnd;
      default:            legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer producing Moore control strobes for the register unit.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned CBUS_W      = 10,
  parameter int unsigned BSEL_W      = 4,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                z_flag,
  input  logic                dram_ack,
  output logic                LDIR,
  output logic                PC_INC,
  output logic                iram_re,
  output logic [CBUS_W-1:0]   C_bus_ctrl_sig,
  output logic [BSEL_W-1:0]   B_bus_sel,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                dram_req,
  output logic                dram_we,
  output logic                done,
  output logic                fault
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [OPCODE_W-1:0] dec_op;
  instr_cls_e          dec_cls;
  logic [ALUOP_W-1:0]  dec_alu;
  logic                dec_legal;

  // Decode the live opcode only while dispatching; everywhere else decode the latched op_q,
  // so outputs remain a function of state and op_q alone.
  assign dec_op = (state_q == StDec) ? opcode : op_q;

  ctrl_decoder #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_dec (
    .opcode_i (dec_op),
    .cls_o    (dec_cls),
    .alu_op_o (dec_alu),
    .legal_o  (dec_legal)
  );

  // State, latched opcode and memory wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state; counter is held at zero outside MRD/MWR so it starts clean on entry
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StF1;
      StF1:   state_d = StF2;
      StF2:   state_d = StDec;
      StDec: begin
        op_d = opcode;
        if (!dec_legal) begin
          state_d = StHalt;
        end else begin
          unique case (dec_cls)
            ClsNop:                       state_d = StF1;
            ClsLdac:                      state_d = StMrd;
            ClsStac:                      state_d = StMwr;
            ClsMvacr, ClsAluR, ClsAluAc:  state_d = StEx;
            ClsJump:                      state_d = StJ1;
            ClsJmpz:                      state_d = z_flag ? StJ1 : StJskip;
            default:                      state_d = StHalt;
          endcase
        end
      end
      StMrd, StMwr: begin
        if (dram_ack) begin
          state_d = (state_q == StMrd) ? StMwb : StF1;
        end else if (cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
          state_d = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StJ1:                         state_d = StJ2;
      StEx, StMwb, StJ2, StJskip:   state_d = StF1;
      StHalt:                       state_d = StHalt;
      default:                      state_d = StIdle;
    endcase
  end

  // Moore output decode
  always_comb begin
    LDIR           = 1'b0;
    PC_INC         = 1'b0;
    iram_re        = 1'b0;
    C_bus_ctrl_sig = '0;
    B_bus_sel      = BSEL_W'(BselNone);
    alu_op         = ALUOP_W'(AluPass);
    dram_req       = 1'b0;
    dram_we        = 1'b0;
    done           = 1'b0;
    fault          = 1'b0;
    unique case (state_q)
      StF1, StJ1: iram_re = 1'b1;
      StF2: begin
        LDIR   = 1'b1;
        PC_INC = 1'b1;
      end
      StEx: begin
        unique case (dec_cls)
          ClsMvacr: begin
            B_bus_sel          = BSEL_W'(BselAc);
            C_bus_ctrl_sig[CR] = 1'b1;
          end
          ClsAluR: begin
            B_bus_sel           = BSEL_W'(BselR);
            alu_op              = dec_alu;
            C_bus_ctrl_sig[CAc] = 1'b1;
          end
          ClsAluAc: begin
            alu_op              = dec_alu;
            C_bus_ctrl_sig[CAc] = 1'b1;
          end
          default: ;
        endcase
      end
      StMrd: dram_req = 1'b1;
      StMwb: begin
        B_bus_sel           = BSEL_W'(BselDr);
        C_bus_ctrl_sig[CAc] = 1'b1;
      end
      StMwr: begin
        dram_req  = 1'b1;
        dram_we   = 1'b1;
        B_bus_sel = BSEL_W'(BselAc);
      end
      StJ2: begin
        B_bus_sel           = BSEL_W'(BselIram);
        C_bus_ctrl_sig[CPc] = 1'b1;
      end
      StJskip: PC_INC = 1'b1;
      StHalt: begin
        // Only END reaches HALT cleanly; illegal opcodes and memory timeouts are faults
        done  = (dec_cls == ClsEnd);
        fault = (dec_cls != ClsEnd);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Cycle-vector bench for control_unit: directed sequences plus random programs.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst, start, z_flag, dram_ack;
  logic [5:0] opcode;
  logic       LDIR, PC_INC, iram_re, dram_req, dram_we, done, fault;
  logic [9:0] C_bus_ctrl_sig;
  logic [3:0] B_bus_sel;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  control_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .opcode         (opcode),
    .z_flag         (z_flag),
    .dram_ack       (dram_ack),
    .LDIR           (LDIR),
    .PC_INC         (PC_INC),
    .iram_re        (iram_re),
    .C_bus_ctrl_sig (C_bus_ctrl_sig),
    .B_bus_sel      (B_bus_sel),
    .alu_op         (alu_op),
    .dram_req       (dram_req),
    .dram_we        (dram_we),
    .done           (done),
    .fault          (fault)
  );

  typedef struct packed {
    logic       iram_re, ldir, pc_inc;
    logic [9:0] cbus;
    logic [3:0] bsel;
    logic [2:0] alu;
    logic       req, we, dn, ft;
  } out_t;

  typedef struct {
    logic       rst, start, z, ak, chk;
    logic [5:0] opc;
    out_t       exp;
    string      tag;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  out_t got;

  assign got = {iram_re, LDIR, PC_INC, C_bus_ctrl_sig, B_bus_sel, alu_op,
                dram_req, dram_we, done, fault};

  function automatic out_t mk(input bit ir, input bit ld, input bit pi, input int cbit,
                              input int bsel, input int alu, input bit rq, input bit we,
                              input bit dn, input bit ft);
    out_t o;
    o = '0;
    o.iram_re = ir;
    o.ldir    = ld;
    o.pc_inc  = pi;
    if (cbit >= 0) o.cbus[cbit] = 1'b1;
    o.bsel = 4'(bsel);
    o.alu  = 3'(alu);
    o.req  = rq;
    o.we   = we;
    o.dn   = dn;
    o.ft   = ft;
    return o;
  endfunction

  function automatic bit jr();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op <= 6'h0A) || (op == 6'h3F);
  endfunction

  task automatic push(input bit r, input bit st, input logic [5:0] opc, input bit z,
                      input bit ak, input bit ck, input out_t e, input string tag);
    vec_t v;
    v.rst = r; v.start = st; v.opc = opc; v.z = z; v.ak = ak; v.chk = ck;
    v.exp = e; v.tag = tag;
    vq.push_back(v);
  endtask

  // Cycle where every input is irrelevant to the expected behaviour
  task automatic cyc(input out_t e, input string tag);
    push(1'b0, jr(), 6'($urandom), jr(), jr(), 1'b1, e, tag);
  endtask

  task automatic do_reset();
    push(1'b1, jr(), 6'($urandom), jr(), jr(), 1'b0, '0, "rst");
    push(1'b0, 1'b0, 6'($urandom), jr(), jr(), 1'b1, '0, "idle");
  endtask

  task automatic do_start();
    push(1'b0, 1'b1, 6'($urandom), jr(), jr(), 1'b1, '0, "start");
  endtask

  // One instruction's full cycle script; d = memory wait cycles before ack (>=15 never)
  task automatic gen_instr(input logic [5:0] op, input bit z, input int d, output int halt);
    int n;
    bit wr;
    halt = 0;
    cyc(mk(1, 0, 0, -1, 0, 0, 0, 0, 0, 0), "f1");
    cyc(mk(0, 1, 1, -1, 0, 0, 0, 0, 0, 0), "f2");
    push(1'b0, jr(), op, z, jr(), 1'b1, '0, "dec");
    case (op)
      6'h00: ;
      6'h01, 6'h02: begin
        wr = (op == 6'h02);
        n  = (d < 15) ? d + 1 : 15;
        for (int i = 0; i < n; i++)
          push(1'b0, jr(), 6'($urandom), jr(), (d < 15 && i == d), 1'b1,
               mk(0, 0, 0, -1, wr ? 3 : 0, 0, 1, wr, 0, 0), wr ? "mwr" : "mrd");
        if (d >= 15) halt = 2;
        else if (!wr) cyc(mk(0, 0, 0, 2, 5, 0, 0, 0, 0, 0), "mwb");
      end
      6'h03: cyc(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0), "mvacr");
      6'h04: cyc(mk(0, 0, 0, 2, 4, 0, 0, 0, 0, 0), "mvrac");
      6'h05: cyc(mk(0, 0, 0, 2, 4, 1, 0, 0, 0, 0), "add");
      6'h06: cyc(mk(0, 0, 0, 2, 4, 2, 0, 0, 0, 0), "sub");
      6'h07: cyc(mk(0, 0, 0, 2, 0, 3, 0, 0, 0, 0), "incac");
      6'h08: cyc(mk(0, 0, 0, 2, 0, 4, 0, 0, 0, 0), "clac");
      6'h09, 6'h0A: begin
        if (op == 6'h09 || z) begin
          cyc(mk(1, 0, 0, -1, 0, 0, 0, 0, 0, 0), "j1");
          cyc(mk(0, 0, 0, 0, 6, 0, 0, 0, 0, 0), "j2");
        end else begin
          cyc(mk(0, 0, 1, -1, 0, 0, 0, 0, 0, 0), "jskip");
        end
      end
      6'h3F:   halt = 1;
      default: halt = 2;
    endcase
  endtask

  // HALT is sticky: start pulses must not move it
  task automatic halt_cycles(input int kind);
    for (int i = 0; i < 4; i++)
      push(1'b0, (i % 2 == 0), 6'($urandom), jr(), jr(), 1'b1,
           mk(0, 0, 0, -1, 0, 0, 0, 0, kind == 1, kind == 2), "halt");
  endtask

  task automatic gen_random();
    logic [5:0] legal_ops[11];
    logic [5:0] op;
    int len, h, r, d;
    legal_ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A};
    h   = 0;
    len = int'($urandom_range(1, 8));
    do_reset();
    do_start();
    for (int k = 0; k < len; k++) begin
      op = legal_ops[$urandom_range(0, 10)];
      r  = int'($urandom_range(0, 9));
      d  = (r < 7) ? int'($urandom_range(0, 4)) : (r == 7) ? 14 : (r == 8) ? 15 : 20;
      gen_instr(op, jr(), d, h);
      if (h != 0) break;
    end
    if (h == 0) begin
      if (jr()) begin
        op = 6'h3F;
      end else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      gen_instr(op, jr(), 0, h);
    end
    halt_cycles(h);
  endtask

  int h;

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; z_flag = 1'b0; dram_ack = 1'b0;

    // NOP, END
    do_reset(); do_start();
    gen_instr(6'h00, 0, 0, h); gen_instr(6'h3F, 0, 0, h); halt_cycles(h);
    // LDAC with 3 wait cycles, then ack on the final allowed cycle
    do_reset(); do_start();
    gen_instr(6'h01, 0, 3, h); gen_instr(6'h01, 0, 14, h); gen_instr(6'h3F, 0, 0, h);
    halt_cycles(h);
    // JMPZ both ways, JUMP, ALU group
    do_reset(); do_start();
    gen_instr(6'h0A, 0, 0, h); gen_instr(6'h0A, 1, 0, h); gen_instr(6'h09, 0, 0, h);
    gen_instr(6'h05, 0, 0, h); gen_instr(6'h06, 0, 0, h); gen_instr(6'h07, 0, 0, h);
    gen_instr(6'h08, 0, 0, h); gen_instr(6'h03, 0, 0, h); gen_instr(6'h04, 0, 0, h);
    gen_instr(6'h02, 0, 0, h); gen_instr(6'h3F, 0, 0, h); halt_cycles(h);
    // STAC never acknowledged
    do_reset(); do_start();
    gen_instr(6'h02, 0, 99, h); halt_cycles(h);
    // Illegal opcodes, including one sharing low bits with END
    do_reset(); do_start(); gen_instr(6'h15, 0, 0, h); halt_cycles(h);
    do_reset(); do_start(); gen_instr(6'h1F, 0, 0, h); halt_cycles(h);
    // Reset in the middle of a memory write, then restart
    do_reset(); do_start();
    cyc(mk(1, 0, 0, -1, 0, 0, 0, 0, 0, 0), "f1");
    cyc(mk(0, 1, 1, -1, 0, 0, 0, 0, 0, 0), "f2");
    push(1'b0, 1'b0, 6'h02, 1'b0, 1'b0, 1'b1, '0, "dec");
    push(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, -1, 3, 0, 1, 1, 0, 0), "mwr");
    push(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, -1, 3, 0, 1, 1, 0, 0), "mwr_rst");
    push(1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b1, '0, "idle_after_rst");
    do_start();
    cyc(mk(1, 0, 0, -1, 0, 0, 0, 0, 0, 0), "restart_f1");

    for (int p = 0; p < 40; p++) gen_random();

    foreach (vq[i]) begin
      @(negedge clk);
      if (vq[i].chk) begin
        n_vec++;
        if (vq[i].tag == "idle" || vq[i].tag == "idle_after_rst") begin
          if (got !== '0) begin
            n_bad++;
            $display("FAIL reset-state %s vec %0d: got %h required all zero",
                     vq[i].tag, i, got);
          end
        end else if (vq[i].tag == "halt") begin
          if (got !== vq[i].exp) begin
            n_bad++;
            $display("FAIL halt/expired-wait vec %0d: got %h required %h (done=%b fault=%b)",
                     i, got, vq[i].exp, done, fault);
          end
        end else begin
          if (got !== vq[i].exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h required %h", vq[i].tag, i, got, vq[i].exp);
          end
        end
      end
      rst      = vq[i].rst;
      start    = vq[i].start;
      opcode   = vq[i].opc;
      z_flag   = vq[i].z;
      dram_ack = vq[i].ak;
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
